// File: rtl/dm_sba_axil_adapter_pkg.sv
// Shared debug-module definitions used by the SBA-to-AXI4-Lite adapter.
// Holds the AXI response encodings and a helper that classifies them.
package dm_sba_axil_adapter_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RespSlvErr) || (resp == RespDecErr);
  endfunction

endpackage

// File: rtl/dm_sba_axil_adapter.sv
// Bridges the debug module's single-outstanding SBA req/gnt/r_valid port onto an
// AXI4-Lite master, with a watchdog that aborts transactions the fabric never answers.
module dm_sba_axil_adapter
  import dm_sba_axil_adapter_pkg::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  input  logic                  req_i,
  input  logic [BusWidth-1:0]   add_i,
  input  logic                  we_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic [BusWidth/8-1:0] be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [BusWidth-1:0]   r_rdata_o,
  output logic                  r_err_o,
  output logic                  timeout_o,
  output logic                  aw_valid_o,
  output logic [BusWidth-1:0]   aw_addr_o,
  input  logic                  aw_ready_i,
  output logic                  w_valid_o,
  output logic [BusWidth-1:0]   w_data_o,
  output logic [BusWidth/8-1:0] w_strb_o,
  input  logic                  w_ready_i,
  input  logic                  b_valid_i,
  input  logic [1:0]            b_resp_i,
  output logic                  b_ready_o,
  output logic                  ar_valid_o,
  output logic [BusWidth-1:0]   ar_addr_o,
  input  logic                  ar_ready_i,
  input  logic                  r_valid_i,
  input  logic [BusWidth-1:0]   r_data_i,
  input  logic [1:0]            r_resp_i,
  output logic                  r_ready_o
);

  typedef enum logic [2:0] {
    StIdle, StReadAddr, StReadResp, StWriteReq, StWriteResp, StAbort
  } state_e;

  localparam int unsigned StrbW   = BusWidth / 8;
  localparam int unsigned CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned FireVal = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  // The counter is compared before it increments, so firing at FireVal means
  // the cycle in which it reaches TimeoutCycles.
  localparam logic [CntW-1:0] CntFire = CntW'(FireVal);

  state_e              state_q, state_d;
  logic                we_q;
  logic [BusWidth-1:0] addr_q, wdata_q, r_rdata_q;
  logic [StrbW-1:0]    be_q;
  logic                ar_valid_q, aw_valid_q, w_valid_q, b_ready_q, r_ready_q;
  logic                r_valid_q, r_err_q, timeout_q;
  logic [CntW-1:0]     cnt_q;

  logic grant, busy, ar_hs, b_hs, r_hs, resp_hs, fire, deliver, abort_fire;
  logic aw_done, w_done;

  always_comb begin
    busy    = (state_q == StReadAddr) || (state_q == StReadResp) ||
              (state_q == StWriteReq) || (state_q == StWriteResp);
    // Holding off grant while the response pulse is out keeps r_valid_o out of grant cycles.
    grant   = (state_q == StIdle) && req_i && dmactive_i && !r_valid_q;
    ar_hs   = ar_valid_q && ar_ready_i;
    b_hs    = b_ready_q && b_valid_i;
    r_hs    = r_ready_q && r_valid_i;
    aw_done = !aw_valid_q || aw_ready_i;
    w_done  = !w_valid_q || w_ready_i;
    resp_hs = ((state_q == StReadResp) && r_hs) || ((state_q == StWriteResp) && b_hs);
    fire    = (TimeoutCycles != 0) && busy && (cnt_q == CntFire) && !resp_hs;

    state_d = state_q;
    case (state_q)
      StIdle:      if (grant) state_d = we_i ? StWriteReq : StReadAddr;
      StReadAddr:  if (ar_hs) state_d = StReadResp;
      StReadResp:  if (r_hs) state_d = StIdle;
      StWriteReq:  if (aw_done && w_done) state_d = StWriteResp;
      StWriteResp: if (b_hs) state_d = StIdle;
      StAbort:     if (we_q ? b_hs : r_hs) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    // A response landing this cycle wins over both watchdog and deactivation.
    if (busy && !resp_hs && (!dmactive_i || fire)) state_d = StAbort;

    deliver    = resp_hs && dmactive_i;
    abort_fire = fire && dmactive_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      r_err_q    <= 1'b0;
      r_rdata_q  <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        we_q       <= we_i;
        addr_q     <= add_i;
        wdata_q    <= wdata_i;
        be_q       <= be_i;
        ar_valid_q <= !we_i;
        aw_valid_q <= we_i;
        w_valid_q  <= we_i;
        cnt_q      <= '0;
      end else begin
        // Valids drop only on their own handshake, in Abort as well.
        ar_valid_q <= ar_valid_q && !ar_ready_i;
        aw_valid_q <= aw_valid_q && !aw_ready_i;
        w_valid_q  <= w_valid_q && !w_ready_i;
        if (busy && (cnt_q != {CntW{1'b1}})) cnt_q <= cnt_q + CntW'(1);
      end
      r_ready_q <= (state_d == StReadResp) || ((state_d == StAbort) && !we_q);
      b_ready_q <= (state_d == StWriteResp) || ((state_d == StAbort) && we_q);
      r_valid_q <= deliver || abort_fire;
      r_err_q   <= abort_fire || (deliver && resp_is_err(we_q ? b_resp_i : r_resp_i));
      r_rdata_q <= (deliver && !we_q && !resp_is_err(r_resp_i)) ? r_data_i : '0;
      if (!dmactive_i)     timeout_q <= 1'b0;
      else if (abort_fire) timeout_q <= 1'b1;
    end
  end

  assign gnt_o      = grant;
  assign r_valid_o  = r_valid_q;
  assign r_rdata_o  = r_rdata_q;
  assign r_err_o    = r_err_q;
  assign timeout_o  = timeout_q;
  assign aw_valid_o = aw_valid_q;
  assign aw_addr_o  = addr_q;
  assign w_valid_o  = w_valid_q;
  assign w_data_o   = wdata_q;
  assign w_strb_o   = be_q;
  assign b_ready_o  = b_ready_q;
  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = addr_q;
  assign r_ready_o  = r_ready_q;

endmodule
